// File: rtl/clock_alarm_ctrl.sv
// Time-of-day controller: BCD hh:mm:ss counter, alarm registers, set/add/beep
// button state machine, display mux, field-flash strobes and beeper timing.
module clock_alarm_ctrl #(
  parameter int NUM_ALARMS   = 2,
  parameter int BEEP_SECONDS = 60,
  parameter int AW           = $clog2(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1s,
  input  logic                  set_pulse,
  input  logic                  add_pulse,
  input  logic                  beep_pulse,
  output logic [23:0]           time_data,
  output logic                  flash_hour,
  output logic                  flash_minute,
  output logic                  flash_second,
  output logic                  mode,
  output logic [AW-1:0]         sel_alarm,
  output logic                  edit_alarm,
  output logic [NUM_ALARMS-1:0] alarm_en,
  output logic                  beep,
  output logic [AW-1:0]         beep_src
);

  // The alarm being edited is carried in idx, so one A_* code covers all alarms.
  typedef enum logic [2:0] {RUN, T_S, T_M, T_H, A_S, A_M, A_H} state_t;

  localparam logic [AW-1:0] LAST_ALARM = AW'(NUM_ALARMS - 1);
  localparam logic [7:0]    BEEP_LAST  = 8'(BEEP_SECONDS - 1);

  state_t        state;
  logic [AW-1:0] idx;
  logic [23:0]   cur_time;
  logic [23:0]   alarm [NUM_ALARMS];
  logic [7:0]    beep_cnt;
  logic [23:0]   next_time;
  logic          fire;
  logic [AW-1:0] fire_idx;
  logic          time_edit;
  logic          alarm_edit;

  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v == 8'h59)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc24(input logic [7:0] v);
    if (v == 8'h23)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Edit increments touch a single field and never carry.
  function automatic logic [23:0] bump(input logic [23:0] v, input state_t f);
    case (f)
      T_S, A_S: return {v[23:8], inc60(v[7:0])};
      T_M, A_M: return {v[23:16], inc60(v[15:8]), v[7:0]};
      default:  return {inc24(v[23:16]), v[15:0]};
    endcase
  endfunction

  assign time_edit  = (state == T_S) || (state == T_M) || (state == T_H);
  assign alarm_edit = (state == A_S) || (state == A_M) || (state == A_H);

  always_comb begin
    next_time       = cur_time;
    next_time[7:0]  = inc60(cur_time[7:0]);
    if (cur_time[7:0] == 8'h59) begin
      next_time[15:8] = inc60(cur_time[15:8]);
      if (cur_time[15:8] == 8'h59)
        next_time[23:16] = inc24(cur_time[23:16]);
    end
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    fire     = 1'b0;
    fire_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (state == RUN && tick_1s && alarm_en[i] && next_time == alarm[i]) begin
        fire     = 1'b1;
        fire_idx = AW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      idx      <= '0;
      cur_time <= '0;
      for (int i = 0; i < NUM_ALARMS; i++)
        alarm[i] <= '0;
      alarm_en <= '0;
      beep     <= 1'b0;
      beep_src <= '0;
      beep_cnt <= '0;
    end else begin
      if (tick_1s && !time_edit)
        cur_time <= next_time;
      if (add_pulse && time_edit)
        cur_time <= bump(cur_time, state);
      if (add_pulse && alarm_edit)
        alarm[idx] <= bump(alarm[idx], state);
      if (beep_pulse && alarm_edit)
        alarm_en[idx] <= ~alarm_en[idx];

      if (fire) begin
        beep     <= 1'b1;
        beep_src <= fire_idx;
        beep_cnt <= '0;
      end else if (beep && tick_1s) begin
        if (beep_cnt == BEEP_LAST) begin
          beep     <= 1'b0;
          beep_cnt <= '0;
        end else begin
          beep_cnt <= beep_cnt + 8'd1;
        end
      end
      if (beep_pulse && state == RUN && beep)
        beep <= 1'b0;

      // A simultaneous add takes precedence over set.
      if (set_pulse && !add_pulse) begin
        case (state)
          RUN: begin
            state    <= T_S;
            beep     <= 1'b0;
            beep_cnt <= '0;
          end
          T_S: state <= T_M;
          T_M: state <= T_H;
          T_H: begin
            state <= A_S;
            idx   <= '0;
          end
          A_S: state <= A_M;
          A_M: state <= A_H;
          default: begin
            if (idx == LAST_ALARM) begin
              state <= RUN;
              idx   <= '0;
            end else begin
              state <= A_S;
              idx   <= idx + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign time_data    = alarm_edit ? alarm[idx] : cur_time;
  assign flash_second = (state == T_S) || (state == A_S);
  assign flash_minute = (state == T_M) || (state == A_M);
  assign flash_hour   = (state == T_H) || (state == A_H);
  assign mode         = (state == RUN);
  assign edit_alarm   = alarm_edit;
  assign sel_alarm    = alarm_edit ? idx : '0;

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// Bench for clock_alarm_ctrl: directed scenarios plus random button/tick traffic,
// all compared each cycle against a seconds-of-day reference model.
module tb_clock_alarm_ctrl;

  localparam int NA      = 2;
  localparam int BS      = 60;
  localparam int AW      = $clog2(NA);
  localparam int NSTATES = 4 + 3 * NA;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_1s = 1'b0;
  logic          set_pulse = 1'b0;
  logic          add_pulse = 1'b0;
  logic          beep_pulse = 1'b0;
  logic [23:0]   time_data;
  logic          flash_hour, flash_minute, flash_second, mode, edit_alarm, beep;
  logic [AW-1:0] sel_alarm, beep_src;
  logic [NA-1:0] alarm_en;

  int checks = 0;
  int passes = 0;

  // Reference model: position 0 = RUN, 1..3 = T_S/T_M/T_H, 4+3*i+f = alarm i field f.
  int          m_pos;
  int          m_time;
  int          m_alarm [NA];
  logic [NA-1:0] m_en;
  bit          m_beep;
  int          m_cnt;
  int          m_src;

  clock_alarm_ctrl #(.NUM_ALARMS(NA), .BEEP_SECONDS(BS)) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .set_pulse(set_pulse),
    .add_pulse(add_pulse), .beep_pulse(beep_pulse), .time_data(time_data),
    .flash_hour(flash_hour), .flash_minute(flash_minute), .flash_second(flash_second),
    .mode(mode), .sel_alarm(sel_alarm), .edit_alarm(edit_alarm), .alarm_en(alarm_en),
    .beep(beep), .beep_src(beep_src)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int sec);
    int h, m, s;
    h = sec / 3600;
    m = (sec / 60) % 60;
    s = sec % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int stepField(input int sec, input int fld);
    int h, m, s;
    h = sec / 3600;
    m = (sec / 60) % 60;
    s = sec % 60;
    if (fld == 0) s = (s + 1) % 60;
    else if (fld == 1) m = (m + 1) % 60;
    else h = (h + 1) % 24;
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got === expv) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
  endtask

  task automatic modelStep(input bit r, input bit s, input bit a, input bit b, input bit t);
    int fld, ai, nt, fi;
    bit fired, ted, aed;
    if (r) begin
      m_pos = 0; m_time = 0; m_en = '0; m_beep = 0; m_cnt = 0; m_src = 0;
      for (int i = 0; i < NA; i++) m_alarm[i] = 0;
      return;
    end
    ted = (m_pos >= 1 && m_pos <= 3);
    aed = (m_pos >= 4);
    ai  = aed ? (m_pos - 4) / 3 : 0;
    fld = aed ? (m_pos - 4) % 3 : (ted ? m_pos - 1 : 0);
    nt  = (m_time + 1) % 86400;
    fired = 0; fi = 0;
    if (m_pos == 0 && t)
      for (int i = NA - 1; i >= 0; i--)
        if (m_en[i] && m_alarm[i] == nt) begin fired = 1; fi = i; end
    if (fired) begin
      m_beep = 1; m_cnt = 0; m_src = fi;
    end else if (m_beep && t) begin
      m_cnt++;
      if (m_cnt == BS) begin m_beep = 0; m_cnt = 0; end
    end
    if (b && m_pos == 0) m_beep = 0;
    if (s && !a && m_pos == 0) begin m_beep = 0; m_cnt = 0; end
    if (t && !ted) m_time = nt;
    if (a && ted) m_time = stepField(m_time, fld);
    if (a && aed) m_alarm[ai] = stepField(m_alarm[ai], fld);
    if (b && aed) m_en[ai] = ~m_en[ai];
    if (s && !a) m_pos = (m_pos + 1) % NSTATES;
  endtask

  task automatic compareAll();
    int fld, ai;
    bit aed;
    aed = (m_pos >= 4);
    ai  = aed ? (m_pos - 4) / 3 : 0;
    fld = aed ? (m_pos - 4) % 3 : -1;
    checkOutput("time_data", 32'(time_data), 32'(aed ? to_bcd(m_alarm[ai]) : to_bcd(m_time)));
    checkOutput("flash_second", 32'(flash_second), 32'(m_pos == 1 || fld == 0));
    checkOutput("flash_minute", 32'(flash_minute), 32'(m_pos == 2 || fld == 1));
    checkOutput("flash_hour", 32'(flash_hour), 32'(m_pos == 3 || fld == 2));
    checkOutput("mode", 32'(mode), 32'(m_pos == 0));
    checkOutput("edit_alarm", 32'(edit_alarm), 32'(aed));
    checkOutput("sel_alarm", 32'(sel_alarm), 32'(ai));
    checkOutput("alarm_en", 32'(alarm_en), 32'(m_en));
    checkOutput("beep", 32'(beep), 32'(m_beep));
    checkOutput("beep_src", 32'(beep_src), 32'(m_src));
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit a, input bit b, input bit t);
    rst = r; set_pulse = s; add_pulse = a; beep_pulse = b; tick_1s = t;
    modelStep(r, s, a, b, t);
    @(posedge clk);
    #1;
    rst = 0; set_pulse = 0; add_pulse = 0; beep_pulse = 0; tick_1s = 0;
    compareAll();
  endtask

  task automatic doSets(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0);
  endtask

  task automatic doAdds(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, 0, 0);
  endtask

  task automatic doTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1);
  endtask

  initial begin
    bit s, a, b, t, r;

    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset_time", 32'(time_data), 32'h0);
    checkOutput("reset_mode", 32'(mode), 32'h1);
    doTicks(3);
    checkOutput("three_ticks", 32'(time_data), 32'h000003);
    checkOutput("three_ticks_beep", 32'(beep), 32'h0);

    // Build 23:59:59, then test the minute wrap while frozen, then the day wrap.
    applyStimulus(1, 0, 0, 0, 0);
    doSets(1); doAdds(59);
    doSets(1); doAdds(59);
    doSets(1); doAdds(23);
    checkOutput("built_max", 32'(time_data), 32'h235959);
    doSets(NSTATES - 3);
    checkOutput("back_to_run", 32'(mode), 32'h1);
    doSets(2);
    doAdds(1);
    checkOutput("mm_wrap", 32'(time_data), 32'h230059);
    doTicks(3);
    checkOutput("frozen", 32'(time_data), 32'h230059);
    doAdds(59);
    doSets(NSTATES - 2);
    doTicks(1);
    checkOutput("day_wrap", 32'(time_data), 32'h000000);

    // State walk and set+add priority.
    applyStimulus(1, 0, 0, 0, 0);
    doSets(4);
    checkOutput("walk_edit_alarm", 32'(edit_alarm), 32'h1);
    checkOutput("walk_sel0", 32'(sel_alarm), 32'h0);
    checkOutput("walk_flash_s", 32'(flash_second), 32'h1);
    doSets(NSTATES - 4);
    checkOutput("walk_mode", 32'(mode), 32'h1);
    doSets(1);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("set_add_ss", 32'(time_data), 32'h000001);
    checkOutput("set_add_state", 32'(flash_second), 32'h1);
    doSets(NSTATES - 1);

    // Alarm 1 at 00:00:05, full beep duration.
    applyStimulus(1, 0, 0, 0, 0);
    doSets(7); doAdds(5);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("alarm_en_10", 32'(alarm_en), 32'h2);
    doSets(3);
    doTicks(4);
    checkOutput("pre_fire", 32'(beep), 32'h0);
    doTicks(1);
    checkOutput("fire_beep", 32'(beep), 32'h1);
    checkOutput("fire_src", 32'(beep_src), 32'h1);
    doTicks(BS - 1);
    checkOutput("beep_hold", 32'(beep), 32'h1);
    doTicks(1);
    checkOutput("beep_done", 32'(beep), 32'h0);

    // Both alarms at 00:00:02, dismissal, then a restart mid-beep.
    applyStimulus(1, 0, 0, 0, 0);
    doSets(4); doAdds(2); applyStimulus(0, 0, 0, 1, 0);
    doSets(3); doAdds(2); applyStimulus(0, 0, 0, 1, 0);
    doSets(3);
    doTicks(2);
    checkOutput("dual_src", 32'(beep_src), 32'h0);
    checkOutput("dual_beep", 32'(beep), 32'h1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("dismiss", 32'(beep), 32'h0);
    doSets(4); doAdds(3);
    doSets(3); doAdds(8);
    doSets(3);
    doTicks(3);
    checkOutput("first_fire", 32'(beep_src), 32'h0);
    doTicks(5);
    checkOutput("refire_src", 32'(beep_src), 32'h1);
    doTicks(BS - 1);
    checkOutput("refire_hold", 32'(beep), 32'h1);
    doTicks(1);
    checkOutput("refire_done", 32'(beep), 32'h0);

    // Beeping then set, then reset from A_H(1).
    applyStimulus(1, 0, 0, 0, 0);
    doSets(4); doAdds(1); applyStimulus(0, 0, 0, 1, 0);
    doSets(6);
    doTicks(1);
    checkOutput("set_fire", 32'(beep), 32'h1);
    doSets(1);
    checkOutput("set_clears_beep", 32'(beep), 32'h0);
    doSets(8);
    checkOutput("in_ah1", 32'(flash_hour & edit_alarm), 32'h1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_mode", 32'(mode), 32'h1);
    checkOutput("rst_en", 32'(alarm_en), 32'h0);
    doSets(NSTATES);

    // Random traffic; tick never coincides with set or beep_pulse.
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 499) == 0);
      t = ($urandom_range(0, 2) == 0);
      s = !t && ($urandom_range(0, 7) == 0);
      b = !t && ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 3) == 0);
      applyStimulus(r, s, a, b, t);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
